// File: rtl/sw_btn_debounce.sv
// Debounces slide switches and a step pushbutton with a shared sample tick,
// and turns each qualified button press into one single-cycle step pulse.
module sw_btn_debounce #(
  parameter int DB_COUNT = 500000,
  parameter int NSW      = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NSW-1:0] switches,
  input  logic           btn_step,
  output logic [NSW-1:0] sw_db,
  output logic           btn_db,
  output logic           step_pulse,
  output logic           sw_change
);

  localparam int CW = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HELD  = 2'd2
  } state_t;

  // Button is carried as the top bit so it shares the switch filter path.
  logic [NSW:0]   raw;
  logic [NSW:0]   meta_q;
  logic [NSW:0]   sync_q;
  logic [NSW:0]   s0_q;
  logic [NSW:0]   s0_d;
  logic [NSW:0]   db_q;
  logic [NSW:0]   db_d;
  logic [NSW-1:0] sw_last_q;
  logic           sw_change_q;
  logic           sw_change_d;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic           tick;
  state_t         state_q;
  state_t         state_d;
  logic           step_pulse_q;

  assign raw = {btn_step, switches};

  assign tick  = (cnt_q == CNT_LAST);
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);
  assign s0_d  = tick ? sync_q : s0_q;

  // A bit is accepted only when two consecutive ticks saw the same level.
  genvar gi;
  generate
    for (gi = 0; gi <= NSW; gi++) begin : g_filter
      assign db_d[gi] = (tick && (sync_q[gi] == s0_q[gi])) ? sync_q[gi] : db_q[gi];
    end
  endgenerate

  assign sw_change_d = (db_q[NSW-1:0] != sw_last_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q      <= '0;
      sync_q      <= '0;
      s0_q        <= '0;
      db_q        <= '0;
      sw_last_q   <= '0;
      sw_change_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      meta_q      <= raw;
      sync_q      <= meta_q;
      s0_q        <= s0_d;
      db_q        <= db_d;
      sw_last_q   <= db_q[NSW-1:0];
      sw_change_q <= sw_change_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (db_q[NSW]) state_d = PRESS;
      PRESS:   state_d = db_q[NSW] ? HELD : IDLE;
      HELD:    if (!db_q[NSW]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      step_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_pulse_q <= (state_d == PRESS);
    end
  end

  assign sw_db      = db_q[NSW-1:0];
  assign btn_db     = db_q[NSW];
  assign step_pulse = step_pulse_q;
  assign sw_change  = sw_change_q;

endmodule

// File: tb/tb_sw_btn_debounce.sv
// Scoreboard bench: a rule-level model predicts every output cycle, a monitor
// compares the DUT against it, and directed phases check event counts.
module tb_sw_btn_debounce;

  localparam int D = 4;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] switches = '0;
  logic         btn_step = 1'b0;
  logic [N-1:0] sw_db;
  logic         btn_db;
  logic         step_pulse;
  logic         sw_change;

  sw_btn_debounce #(.DB_COUNT(D), .NSW(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .switches   (switches),
    .btn_step   (btn_step),
    .sw_db      (sw_db),
    .btn_db     (btn_db),
    .step_pulse (step_pulse),
    .sw_change  (sw_change)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int chg_cnt = 0;
  int step_cnt = 0;

  typedef struct packed {
    logic [N-1:0] sw;
    logic         btn;
    logic         step;
    logic         chg;
  } exp_t;

  exp_t exp_q[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[%0t] FAIL %s: got %0h expected %0h", $time, name, act, expv);
    end
  endtask

  // Reference model: raw history per clock edge since reset release; a tick
  // falls on every D-th edge and samples the level seen two edges earlier.
  logic [N:0] hist[$];
  int         m_e = 0;
  logic [N:0] m_s = '0;
  logic [N:0] db_now = '0;
  logic [N:0] db_before = '0;

  always @(posedge clk) begin : model
    exp_t       x;
    logic [N:0] nxt;
    logic [N:0] v;
    x = '0;
    if (!reset) begin
      hist.delete();
      m_e       = 0;
      m_s       = '0;
      db_now    = '0;
      db_before = '0;
    end else begin
      m_e++;
      hist.push_back({btn_step, switches});
      nxt = db_now;
      if (m_e % D == 0) begin
        v = (m_e - 2 >= 1) ? hist[m_e - 3] : '0;
        for (int b = 0; b <= N; b++) begin
          if (v[b] == m_s[b]) nxt[b] = v[b];
        end
        m_s = v;
      end
      x.sw   = nxt[N-1:0];
      x.btn  = nxt[N];
      x.chg  = (db_now[N-1:0] != db_before[N-1:0]);
      x.step = db_now[N] & ~db_before[N];
      db_before = db_now;
      db_now    = nxt;
    end
    exp_q.push_back(x);
  end

  always @(negedge clk) begin : monitor
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      if (!reset) x = '0;
      cmp("sw_db", 32'(sw_db), 32'(x.sw));
      cmp("btn_db", 32'(btn_db), 32'(x.btn));
      cmp("step_pulse", 32'(step_pulse), 32'(x.step));
      cmp("sw_change", 32'(sw_change), 32'(x.chg));
      if (reset) begin
        if (sw_change) chg_cnt++;
        if (step_pulse) step_cnt++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin : stim
    int sw_hold;
    int bt_hold;
    int rs_hold;
    logic [N-1:0] flip;

    // Power-up with switches already at A5.
    reset = 1'b0; switches = 8'hA5; btn_step = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(11);
    cmp("p1_sw_db_latency", 32'(sw_db), 32'hA5);
    cyc(3);
    cmp("p1_chg_cnt", chg_cnt, 1);
    cmp("p1_step_cnt", step_cnt, 0);
    $display("[%0t] phase1 power-up A5: sw_db=%0h changes=%0d steps=%0d", $time, sw_db, chg_cnt, step_cnt);

    // Single-cycle glitch on switches[0].
    switches = '0;
    cyc(20);
    chg_cnt = 0;
    cyc(5);
    switches = 8'h01;
    cyc(1);
    switches = '0;
    cyc(20);
    cmp("p2_sw0", 32'(sw_db[0]), 0);
    cmp("p2_chg_cnt", chg_cnt, 0);
    $display("[%0t] phase2 glitch: sw_db=%0h changes=%0d", $time, sw_db, chg_cnt);

    // Long press then release.
    step_cnt = 0;
    btn_step = 1'b1;
    cyc(40);
    btn_step = 1'b0;
    cyc(11);
    cmp("p3_btn_db_release", 32'(btn_db), 0);
    cyc(5);
    cmp("p3_step_cnt", step_cnt, 1);
    $display("[%0t] phase3 hold 40: steps=%0d", $time, step_cnt);

    // Three separate presses.
    step_cnt = 0;
    repeat (3) begin
      btn_step = 1'b1;
      cyc(20);
      btn_step = 1'b0;
      cyc(20);
    end
    cmp("p4_step_cnt", step_cnt, 3);
    $display("[%0t] phase4 three presses: steps=%0d", $time, step_cnt);

    // Reset while held, button still held afterwards.
    btn_step = 1'b1;
    cyc(20);
    cmp("p5_btn_db_held", 32'(btn_db), 1);
    step_cnt = 0;
    reset = 1'b0;
    #1;
    cmp("p5_rst_sw_db", 32'(sw_db), 0);
    cmp("p5_rst_btn_db", 32'(btn_db), 0);
    cmp("p5_rst_step", 32'(step_pulse), 0);
    cmp("p5_rst_chg", 32'(sw_change), 0);
    cyc(3);
    reset = 1'b1;
    cyc(20);
    cmp("p5_step_cnt", step_cnt, 1);
    $display("[%0t] phase5 reset while held: steps=%0d", $time, step_cnt);
    btn_step = 1'b0;
    cyc(20);

    // All switches flip together.
    chg_cnt = 0;
    switches = 8'hFF;
    cyc(12);
    cmp("p6_sw_db", 32'(sw_db), 32'hFF);
    cyc(2);
    cmp("p6_chg_cnt", chg_cnt, 1);
    $display("[%0t] phase6 00->FF: sw_db=%0h changes=%0d", $time, sw_db, chg_cnt);

    // Randomized bouncing inputs with occasional resets.
    sw_hold = 0; bt_hold = 0; rs_hold = 0;
    chg_cnt = 0; step_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rs_hold > 0) begin
        rs_hold--;
        if (rs_hold == 0) reset = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        reset = 1'b0;
        rs_hold = $urandom_range(1, 3);
      end
      if (sw_hold == 0) begin
        flip = N'($urandom_range(1, 255));
        switches = switches ^ flip;
        sw_hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 30);
      end else begin
        sw_hold--;
      end
      if (bt_hold == 0) begin
        btn_step = ~btn_step;
        bt_hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 40);
      end else begin
        bt_hold--;
      end
      cyc(1);
    end
    reset = 1'b1;
    cyc(30);
    $display("[%0t] phase7 random: changes=%0d steps=%0d", $time, chg_cnt, step_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
